// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation and vectoring modes.
// Define CORDIC_QUAD_EXT_EN to add quadrant pre-rotation at accept (full +/-180 deg coverage).
module cordic_iter_engine #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ANGLE_W = 32,
  parameter int unsigned ITER    = 16,
  parameter int unsigned GUARD   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic [WIDTH-1:0]   x_in,
  input  logic [WIDTH-1:0]   y_in,
  input  logic [ANGLE_W-1:0] target_angle,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   x_out,
  output logic [WIDTH-1:0]   y_out,
  output logic [ANGLE_W-1:0] angle_out,
  output logic               mode_out,
  output logic               ovf
);

  localparam int unsigned IntW = WIDTH + GUARD;
  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned Frac = 64;
  localparam int unsigned TabW = 192;
  localparam logic [CntW-1:0]    LastIter   = CntW'(ITER - 1);
  localparam logic [ANGLE_W-1:0] Quarter    = ANGLE_W'(1) << (ANGLE_W - 2);
  localparam logic [ANGLE_W-1:0] NegQuarter = ~Quarter + ANGLE_W'(1);

  // atan(1/n) in fixed point with Frac fraction bits, alternating Taylor series.
  function automatic logic [TabW-1:0] atan_recip(input logic [TabW-1:0] n);
    logic [TabW-1:0] one, pw, acc, term;
    logic            done;
    one  = TabW'(1) << Frac;
    pw   = n;
    acc  = '0;
    done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (!done) begin
        term = one / (pw * TabW'(2 * k + 1));
        if (k % 2 == 0) acc = acc + term;
        else            acc = acc - term;
        if (pw > one) done = 1'b1;
        else          pw = pw * n * n;
      end
    end
    return acc;
  endfunction

  // round(atan(2^-i) * 2^ANGLE_W / (2*pi)); pi from Machin's formula.
  function automatic logic [ANGLE_W-1:0] atan_entry(input int unsigned i);
    logic [TabW-1:0]    pi_fix, num, den;
    logic [ANGLE_W-1:0] res;
    if (i == 0) begin
      res = ANGLE_W'(1) << (ANGLE_W - 3);
    end else begin
      pi_fix = (atan_recip(TabW'(5)) << 4) - (atan_recip(TabW'(239)) << 2);
      num    = atan_recip(TabW'(1) << i) << ANGLE_W;
      den    = pi_fix << 1;
      res    = ANGLE_W'((num + (den >> 1)) / den);
    end
    return res;
  endfunction

  // Returns {ovf, clamped value}.
  function automatic logic [WIDTH:0] sat(input logic signed [IntW-1:0] v);
    logic [WIDTH:0] r;
    if (v[IntW-1:WIDTH-1] != {(GUARD + 1){v[IntW-1]}}) begin
      r = v[IntW-1] ? {2'b11, {(WIDTH - 1){1'b0}}} : {2'b10, {(WIDTH - 1){1'b1}}};
    end else begin
      r = {1'b0, v[WIDTH-1:0]};
    end
    return r;
  endfunction

  logic [ANGLE_W-1:0] atan_tab [ITER];
  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam logic [ANGLE_W-1:0] AtanVal = atan_entry(g);
    assign atan_tab[g] = AtanVal;
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        iter_q, iter_d;
  logic signed [IntW-1:0] x_q, x_d, y_q, y_d;
  logic [ANGLE_W-1:0]     z_q, z_d, target_q, target_d;
  logic                   mode_q, mode_d;
  logic [WIDTH-1:0]       x_out_q, x_out_d, y_out_q, y_out_d;
  logic [ANGLE_W-1:0]     angle_out_q, angle_out_d;
  logic                   mode_out_q, mode_out_d, ovf_q, ovf_d;

  logic signed [IntW-1:0] x_ext, y_ext, ld_x, ld_y;
  logic [ANGLE_W-1:0]     ld_z;
  logic signed [IntW-1:0] x_sh, y_sh, x_nx, y_nx;
  logic [ANGLE_W-1:0]     z_nx;
  logic                   d_pos;
  logic [WIDTH:0]         x_sat, y_sat;

  assign x_ext = {{GUARD{x_in[WIDTH-1]}}, x_in};
  assign y_ext = {{GUARD{y_in[WIDTH-1]}}, y_in};

  always_comb begin
    ld_x = x_ext;
    ld_y = y_ext;
    ld_z = '0;
`ifdef CORDIC_QUAD_EXT_EN
    if (!mode) begin
      if ($signed(target_angle) > $signed(Quarter)) begin
        ld_x = -y_ext;
        ld_y = x_ext;
        ld_z = Quarter;
      end else if ($signed(target_angle) < $signed(NegQuarter)) begin
        ld_x = y_ext;
        ld_y = -x_ext;
        ld_z = NegQuarter;
      end
    end else if (x_in[WIDTH-1]) begin
      // Bring a left-half-plane vector into the right half plane; z records the offset.
      if (!y_in[WIDTH-1]) begin
        ld_x = y_ext;
        ld_y = -x_ext;
        ld_z = Quarter;
      end else begin
        ld_x = -y_ext;
        ld_y = x_ext;
        ld_z = NegQuarter;
      end
    end
`endif
  end

  always_comb begin
    x_sh  = x_q >>> iter_q;
    y_sh  = y_q >>> iter_q;
    d_pos = mode_q ? y_q[IntW-1] : ($signed(z_q) < $signed(target_q));
    if (d_pos) begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
    end else begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
    end
    // Vectoring accumulates the input vector's angle, hence the opposite z sense.
    z_nx = (d_pos ^ mode_q) ? z_q + atan_tab[iter_q] : z_q - atan_tab[iter_q];
  end

  assign x_sat = sat(x_nx);
  assign y_sat = sat(y_nx);

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    target_d    = target_q;
    mode_d      = mode_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    angle_out_d = angle_out_q;
    mode_out_d  = mode_out_q;
    ovf_d       = ovf_q;
    in_ready    = (state_q == StIdle);
    out_valid   = (state_q == StDone);
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d      = ld_x;
          y_d      = ld_y;
          z_d      = ld_z;
          target_d = target_angle;
          mode_d   = mode;
          iter_d   = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        x_d = x_nx;
        y_d = y_nx;
        z_d = z_nx;
        if (iter_q == LastIter) begin
          x_out_d     = x_sat[WIDTH-1:0];
          y_out_d     = y_sat[WIDTH-1:0];
          angle_out_d = z_nx;
          mode_out_d  = mode_q;
          ovf_d       = x_sat[WIDTH] | y_sat[WIDTH];
          iter_d      = '0;
          state_d     = StDone;
        end else begin
          iter_d = iter_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      iter_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      target_q    <= '0;
      mode_q      <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      angle_out_q <= '0;
      mode_out_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      target_q    <= target_d;
      mode_q      <= mode_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      angle_out_q <= angle_out_d;
      mode_out_q  <= mode_out_d;
      ovf_q       <= ovf_d;
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign angle_out = angle_out_q;
  assign mode_out  = mode_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed self-checking bench for cordic_iter_engine (WIDTH=16, ANGLE_W=16, ITER=14).
module tb_cordic_iter_engine;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned NI = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          mode;
  logic [W-1:0]  x_in;
  logic [W-1:0]  y_in;
  logic [AW-1:0] target_angle;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  x_out;
  logic [W-1:0]  y_out;
  logic [AW-1:0] angle_out;
  logic          mode_out;
  logic          ovf;

  int n_checks = 0;
  int n_errors = 0;

  cordic_iter_engine #(
    .WIDTH  (W),
    .ANGLE_W(AW),
    .ITER   (NI),
    .GUARD  (2)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mode        (mode),
    .x_in        (x_in),
    .y_in        (y_in),
    .target_angle(target_angle),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .x_out       (x_out),
    .y_out       (y_out),
    .angle_out   (angle_out),
    .mode_out    (mode_out),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp,
                           input longint tol = 0);
    n_checks++;
    if (got > exp + tol || got < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic drive(input logic m, input longint x, input longint y, input longint t);
    mode         = m;
    x_in         = x[W-1:0];
    y_in         = y[W-1:0];
    target_angle = t[AW-1:0];
    in_valid     = 1'b1;
  endtask

  // Presents one operand for a single edge; returns #1 after the accept edge.
  task automatic issue(input logic m, input longint x, input longint y, input longint t);
    @(negedge clk);
    drive(m, x, y, t);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
    check_val(tag, n, NI);
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    mode         = 1'b0;
    x_in         = '0;
    y_in         = '0;
    target_angle = '0;
    #12;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_x_out", x_out, 0);
    check_val("rst_angle_out", angle_out, 0);
    check_val("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Rotation by +45 deg.
    issue(1'b0, 9949, 0, 'h2000);
    check_val("rot_busy_in_ready", in_ready, 0);
    wait_done("rot_latency");
    check_val("rot_x", longint'($signed(x_out)), 11585, 4);
    check_val("rot_y", longint'($signed(y_out)), 11585, 4);
    check_val("rot_angle", longint'($signed(angle_out)), 'h2000, 2);
    check_val("rot_ovf", ovf, 0);
    check_val("rot_mode", mode_out, 0);
    retire();
    check_val("rot_retired", out_valid, 0);

    // Vectoring of (10000, 10000).
    issue(1'b1, 10000, 10000, 0);
    wait_done("vec_latency");
    check_val("vec_angle", longint'($signed(angle_out)), 'h2000, 2);
    check_val("vec_x", longint'($signed(x_out)), 23289, 6);
    check_val("vec_y", longint'($signed(y_out)), 0, 4);
    check_val("vec_mode", mode_out, 1);
    check_val("vec_ovf", ovf, 0);
    retire();

    // Saturating vectoring, then hold the result under backpressure with a pending operand.
    issue(1'b1, 32767, 32767, 0);
    wait_done("sat_latency");
    check_val("sat_x", longint'($signed(x_out)), 32767);
    check_val("sat_ovf", ovf, 1);
    drive(1'b0, 9949, 0, 'h2000);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_val("bp_out_valid", out_valid, 1);
      check_val("bp_in_ready", in_ready, 0);
      check_val("bp_x_hold", longint'($signed(x_out)), 32767);
      check_val("bp_ovf_hold", ovf, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val("hs_no_accept", in_ready, 1);
    check_val("hs_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("pend_accepted", in_ready, 0);
    wait_done("pend_latency");
    check_val("pend_x", longint'($signed(x_out)), 11585, 4);
    check_val("pend_y", longint'($signed(y_out)), 11585, 4);
    retire();

    // Asynchronous reset at RUN iteration 5.
    issue(1'b0, 9949, 0, 'h2000);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_in_ready", in_ready, 1);
    check_val("mid_rst_x_out", x_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 10000, 10000, 0);
    wait_done("post_rst_latency");
    check_val("post_rst_angle", longint'($signed(angle_out)), 'h2000, 2);
    check_val("post_rst_x", longint'($signed(x_out)), 23289, 6);
    retire();

    // Rotation to 135 deg.
    issue(1'b0, 9949, 0, 'h6000);
    wait_done("q2_latency");
`ifdef CORDIC_QUAD_EXT_EN
    check_val("q2_x", longint'($signed(x_out)), -11585, 4);
    check_val("q2_y", longint'($signed(y_out)), 11585, 4);
    check_val("q2_angle", longint'(angle_out), 'h6000, 2);
`else
    // Target out of reach: every step is positive, so z is the full table sum.
    check_val("q2_angle_sat", longint'(angle_out), 18181);
`endif
    retire();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
